overlay_mac_sequencer: RTL and testbench
========================================

Name: overlay_mac_sequencer

Overview:
Issue/drain controller for the 27x18 MAC overlay (Overlay_27bits_18bits). It accepts a valid/ready stream of (a, b, last) operand pairs and drives the overlay's a/b/mode/result_2/CIN inputs. It feeds S_reg back as result_2 so each vector is accumulated into a dot product. It captures the final S_reg/COUT_reg of each vector and returns it on a valid/ready result stream. It sits between operand memories/feeders and the overlay, and owns both the overlay's operand side and its result side.

Parameters:
OUT_DEPTH, 2, result FIFO entries (min 2)
CNT_W, 16, width of element counter per vector
MODE_SUM, 2'b00, overlay mode code selecting S = W + Y + X + CIN

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset; also drives overlay reset
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer accepts pair this cycle
in_a  in  27  multiplicand
in_b  in  18  multiplier
in_last  in  1  final pair of current vector
ov_mode  out  2  to overlay mode
ov_a  out  27  to overlay a
ov_b  out  18  to overlay b
ov_result_2  out  48  to overlay result_2 (accumulator feedback)
ov_cin  out  1  to overlay CIN
ov_s  in  48  from overlay S_reg
ov_cout  in  1  from overlay COUT_reg
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_data  out  48  dot-product sum
out_carry  out  1  OR of ov_cout over all elements of the vector
out_count  out  CNT_W  number of pairs in the vector (saturating)

Behaviour:
- Issue stage (cycle t): fire = in_valid & in_ready. On fire, ov_a/ov_b = in_a/in_b. Otherwise ov_a = 0 and ov_b = 0 (bubble; products zero, accumulation preserved). ov_a/ov_b are combinational from inputs/fire.
- ov_mode = MODE_SUM and ov_cin = 0, constant.
- Tag pipe mirrors the overlay latency of 2:
  - p1 {valid, first, last} is registered at t+1, while the overlay product registers hold the pair.
  - p2 {valid, last} is registered at t+2, when ov_s includes the pair.
- first = the pair is the first after reset or after an accepted last.
- ov_result_2 = (p1.valid & p1.first) ? 0 : ov_s (combinational). This gives back-to-back accumulation at one pair per cycle. Bubbles inside a vector are allowed.
- Carry/count: at each p2.valid, the carry accumulator ORs in ov_cout and the count increments, saturating at all-ones. Both restart (load ov_cout and 1) when p2 marks the first element, carried as p2.first.
- Completion: on p2.valid & p2.last, push {ov_s, carry | ov_cout, count+1} into the result FIFO. A vector of length 1 (first and last on the same pair) is legal.
- Result FIFO (OUT_DEPTH entries):
  - out_valid = !empty; out_data/out_carry/out_count come from the head.
  - A pop occurs when out_valid & out_ready.
  - A simultaneous push and pop on a full FIFO is legal.
- Credit rule (the overlay cannot stall):
  - inflight = number of last-tagged pairs in p1/p2.
  - in_ready = (fifo_count + inflight) < OUT_DEPTH.
  - in_ready is deasserted for all pairs, last or not, so a push can never find the FIFO full.
- Reset: the FIFO is emptied, tags are cleared, and first = 1. Outputs: out_valid = 0, out_data = 0, out_carry = 0, out_count = 0, in_ready = 1 on the first cycle after reset. A reset mid-vector abandons the partial sum, with no output for it.
- Idle with no vector open: bubbles drive zero products. ov_s values are ignored until the next first pair.

Decomposition:
- Package overlay_pkg holds:
  - width constants: A_W = 27, B_W = 18, S_W = 48
  - OV_LAT = 2
  - mode codes MODE_SUM = 2'b00 and the others
  - a struct for the tag {valid, first, last}
- Sub-module overlay_result_fifo: a synchronous FIFO holding {data, carry, count} with count output. The sequencer instantiates it and the overlay sits beside it at top level.

Test Plan:
- Pairs (3,4), (5,6), (7,8, last) back-to-back -> one result: out_data = 98, out_carry = 0, out_count = 3. out_valid rises 2 cycles after the last pair is accepted.
- Two vectors back-to-back with no gap, [(2,2, last)] then [(10,10), (1,1, last)] -> results 4 then 101. The second sum must exclude 4 (first-pair feedback zeroed).
- Same vector as the first test with in_valid dropped for 3 cycles between pairs -> still 98.
- out_ready held 0, then vectors streamed until stall -> exactly OUT_DEPTH results are held and in_ready = 0. Releasing out_ready drains them in order with no loss or duplication.
- Accumulation overflow: pairs (0x3FFFFFF, 0x1FFFF) repeated past 2^48 -> out_carry = 1 on that vector. The next small vector shows out_carry = 0.
- Reset asserted after 2 pairs of a 4-pair vector, then a fresh vector [(1,5, last)] -> the only output is 5 with count 1.

Source files
------------

// File: rtl/overlay_pkg.sv
// Shared widths, latency, mode codes and tag type for the 27x18 MAC overlay
// and its issue/drain sequencer.
package overlay_pkg;

  localparam int A_W    = 27;
  localparam int B_W    = 18;
  localparam int S_W    = 48;
  localparam int OV_LAT = 2;

  // S = W + Y + X + CIN, with W the product and Y/X the feedback operands
  localparam logic [1:0] MODE_SUM  = 2'b00;
  localparam logic [1:0] MODE_MULT = 2'b01;
  localparam logic [1:0] MODE_SUB  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/overlay_result_fifo.sv
// Small synchronous FIFO of finished dot products {data, carry, count}; the
// head is presented combinationally and reads as zero while empty.
module overlay_result_fifo
  import overlay_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [S_W-1:0]             push_data,
  input  logic                       push_carry,
  input  logic [CNT_W-1:0]           push_count,
  input  logic                       pop,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [S_W-1:0]             head_data,
  output logic                       head_carry,
  output logic [CNT_W-1:0]           head_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FC_W  = $clog2(DEPTH + 1);

  logic [S_W-1:0]   data_mem  [DEPTH];
  logic             carry_mem [DEPTH];
  logic [CNT_W-1:0] count_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [FC_W-1:0]  count_reg;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign pop_ok  = pop & ~empty;
  // a push into a full FIFO is only taken when the head leaves in the same cycle
  assign push_ok = push & ((count_reg != FC_W'(DEPTH)) | pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + FC_W'(push_ok) - FC_W'(pop_ok);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
          data_mem[gi]  <= push_data;
          carry_mem[gi] <= push_carry;
          count_mem[gi] <= push_count;
        end
      end
    end
  endgenerate

  assign head_data  = empty ? '0   : data_mem[rd_ptr_reg];
  assign head_carry = empty ? 1'b0 : carry_mem[rd_ptr_reg];
  assign head_count = empty ? '0   : count_mem[rd_ptr_reg];

endmodule

// File: rtl/overlay_mac_sequencer.sv
// Issue/drain controller for the 27x18 MAC overlay: streams operand pairs in,
// feeds S_reg back for dot-product accumulation, and queues each vector result.
module overlay_mac_sequencer
  import overlay_pkg::*;
#(
  parameter int         OUT_DEPTH = 2,
  parameter int         CNT_W     = 16,
  parameter logic [1:0] MODE_SUM  = overlay_pkg::MODE_SUM
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             in_last,

  output logic [1:0]       ov_mode,
  output logic [A_W-1:0]   ov_a,
  output logic [B_W-1:0]   ov_b,
  output logic [S_W-1:0]   ov_result_2,
  output logic             ov_cin,
  input  logic [S_W-1:0]   ov_s,
  input  logic             ov_cout,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [S_W-1:0]   out_data,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);

  localparam int FC_W = $clog2(OUT_DEPTH + 1);
  localparam int IF_W = $clog2(OV_LAT + 1);

  logic             fire;
  tag_t             issue_tag;
  tag_t             tag_pipe_reg [OV_LAT];
  tag_t             p1;
  tag_t             p2;
  logic             first_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] count_reg;
  logic             carry_next;
  logic [CNT_W-1:0] count_next;
  logic [IF_W-1:0]  inflight;
  logic [FC_W-1:0]  fifo_count;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // ---------------- issue stage ----------------
  assign fire    = in_valid & in_ready;
  assign ov_a    = fire ? in_a : '0;
  assign ov_b    = fire ? in_b : '0;
  assign ov_mode = MODE_SUM;
  assign ov_cin  = 1'b0;

  assign issue_tag.valid = fire;
  assign issue_tag.first = fire & first_reg;
  assign issue_tag.last  = fire & in_last;

  always_ff @(posedge clk) begin
    if (reset)     first_reg <= 1'b1;
    else if (fire) first_reg <= in_last;
  end

  // ---------------- tag pipe, one stage per overlay register ----------------
  generate
    for (genvar gi = 0; gi < OV_LAT; gi++) begin : g_tag
      always_ff @(posedge clk) begin
        if (reset) begin
          tag_pipe_reg[gi] <= '0;
        end else begin
          if (gi == 0) tag_pipe_reg[gi] <= issue_tag;
          else         tag_pipe_reg[gi] <= tag_pipe_reg[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  assign p1 = tag_pipe_reg[0];
  assign p2 = tag_pipe_reg[OV_LAT-1];

  // the first pair of a vector must not pick up the previous vector's sum
  assign ov_result_2 = (p1.valid & p1.first) ? '0 : ov_s;

  // ---------------- credit: every last in flight owns a FIFO slot ----------------
  always_comb begin
    inflight = '0;
    for (int i = 0; i < OV_LAT; i++) begin
      inflight = inflight + IF_W'(tag_pipe_reg[i].last);
    end
  end

  assign in_ready = (int'(fifo_count) + int'(inflight)) < OUT_DEPTH;

  // ---------------- carry / count accumulation at S_reg time ----------------
  always_comb begin
    carry_next = (p2.first ? 1'b0 : carry_reg) | ov_cout;
    if (p2.first)        count_next = CNT_W'(1);
    else if (&count_reg) count_next = count_reg;
    else                 count_next = count_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_reg <= 1'b0;
      count_reg <= '0;
    end else if (p2.valid) begin
      carry_reg <= carry_next;
      count_reg <= count_next;
    end
  end

  assign push = p2.valid & p2.last;

  // ---------------- result queue ----------------
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  overlay_result_fifo #(
    .DEPTH (OUT_DEPTH),
    .CNT_W (CNT_W)
  ) u_result_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (ov_s),
    .push_carry (carry_next),
    .push_count (count_next),
    .pop        (pop),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head_data  (out_data),
    .head_carry (out_carry),
    .head_count (out_count)
  );

endmodule

// File: tb/tb_overlay_mac_sequencer.sv
// Sequencer bench: a behavioural 2-cycle overlay closes the loop, a queue of
// hand-computed results is checked by an independent output monitor.
module tb_overlay_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_a;
  logic [17:0] in_b;
  logic        in_last;
  logic [1:0]  ov_mode;
  logic [26:0] ov_a;
  logic [17:0] ov_b;
  logic [47:0] ov_result_2;
  logic        ov_cin;
  logic [47:0] ov_s;
  logic        ov_cout;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic        out_carry;
  logic [15:0] out_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [47:0] data;
    logic        carry;
    logic [15:0] count;
  } res_t;

  res_t exp_q[$];

  always #5 clk = ~clk;

  overlay_mac_sequencer #(
    .OUT_DEPTH (2),
    .CNT_W     (16),
    .MODE_SUM  (2'b00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_last     (in_last),
    .ov_mode     (ov_mode),
    .ov_a        (ov_a),
    .ov_b        (ov_b),
    .ov_result_2 (ov_result_2),
    .ov_cin      (ov_cin),
    .ov_s        (ov_s),
    .ov_cout     (ov_cout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_carry   (out_carry),
    .out_count   (out_count)
  );

  // overlay model: product register, then S_reg/COUT_reg = product + result_2 + CIN
  logic [44:0] ov_prod_reg;
  logic [48:0] ov_sum;
  assign ov_sum = {4'b0, ov_prod_reg} + {1'b0, ov_result_2} + {48'b0, ov_cin};

  always @(posedge clk) begin
    if (reset) begin
      ov_prod_reg <= '0;
      ov_s        <= '0;
      ov_cout     <= 1'b0;
    end else begin
      ov_prod_reg <= {18'b0, ov_a} * {27'b0, ov_b};
      ov_s        <= ov_sum[47:0];
      ov_cout     <= ov_sum[48];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_result(input logic [47:0] d, input logic c, input logic [15:0] n);
    res_t r;
    r.data  = d;
    r.carry = c;
    r.count = n;
    exp_q.push_back(r);
  endtask

  // drive one pair and hold it until the sequencer accepts it
  task automatic send(input logic [26:0] a, input logic [17:0] b, input logic last);
    logic acc;
    int   cyc;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    cyc      = 0;
    acc      = 1'b0;
    while (!acc && cyc < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0d required=<1000 cycles", cyc);
    end
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // monitor: compare every result handed over against the queue head
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      $display("result data=%0h carry=%0d count=%0d", out_data, out_carry, out_count);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", out_data);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        chk("out_data",  64'(out_data),  64'(r.data));
        chk("out_carry", 64'(out_carry), 64'(r.carry));
        chk("out_count", 64'(out_count), 64'(r.count));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_carry", 64'(out_carry), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("ov_mode",       64'(ov_mode),   64'd0);
    chk("ov_cin",        64'(ov_cin),    64'd0);
    @(posedge clk);
    #1;

    // 3*4 + 5*6 + 7*8 = 98; result pushed two edges after the last is accepted
    expect_result(48'd98, 1'b0, 16'd3);
    send(27'd3, 18'd4, 1'b0);
    send(27'd5, 18'd6, 1'b0);
    send(27'd7, 18'd8, 1'b1);
    @(negedge clk);
    chk("lat_cycle1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle3", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    wait_drain("drain_t1");

    // back-to-back vectors: 2*2 = 4, then 10*10 + 1*1 = 101
    expect_result(48'd4, 1'b0, 16'd1);
    expect_result(48'd101, 1'b0, 16'd2);
    send(27'd2, 18'd2, 1'b1);
    send(27'd10, 18'd10, 1'b0);
    send(27'd1, 18'd1, 1'b1);
    wait_drain("drain_t2");

    // bubbles inside a vector preserve the running sum
    expect_result(48'd98, 1'b0, 16'd3);
    send(27'd3, 18'd4, 1'b0);
    idle(3);
    send(27'd5, 18'd6, 1'b0);
    idle(3);
    send(27'd7, 18'd8, 1'b1);
    wait_drain("drain_t3");

    // consumer stalled: two results held, input blocked, then drained in order
    out_ready = 1'b0;
    expect_result(48'd1, 1'b0, 16'd1);
    send(27'd1, 18'd1, 1'b1);
    expect_result(48'd2, 1'b0, 16'd1);
    send(27'd2, 18'd1, 1'b1);
    expect_result(48'd3, 1'b0, 16'd1);
    fork
      send(27'd3, 18'd1, 1'b1);
      begin
        repeat (6) @(negedge clk);
        chk("stall_in_ready",  64'(in_ready),  64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_held",      64'(out_data),  64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain("drain_t4");

    // 33 * (2^26-1)*(2^17-1) wraps 2^48 once
    expect_result(48'h7FF7BBE0021, 1'b1, 16'd33);
    for (int i = 0; i < 33; i++) begin
      send(27'h3FFFFFF, 18'h1FFFF, (i == 32));
    end
    expect_result(48'd6, 1'b0, 16'd1);
    send(27'd2, 18'd3, 1'b1);
    wait_drain("drain_t5");

    // reset mid-vector drops the partial sum
    send(27'd1, 18'd1, 1'b0);
    send(27'd2, 18'd2, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk);
    #1;
    expect_result(48'd5, 1'b0, 16'd1);
    send(27'd1, 18'd5, 1'b1);
    wait_drain("drain_t6");

    idle(5);
    @(negedge clk);
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
